// File: rtl/gate_exerciser.sv
// gate_exerciser: exhaustive 16-vector tester for a 4-input complex CMOS gate
// whose expected function is f = ~((a & b) | (a & c) | (b & d)).
//
// Parameters:
//   SETTLE_CYC - idle cycles between driving a vector and sampling (1..15)
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - begin a run (accepted in IDLE or DONE only)
//   dut_f     - output of the gate under test
//   a,b,c,d   - registered stimulus, {a,b,c,d} = vector, a is MSB
//   busy      - run in progress
//   done      - run finished, held until next accepted start or reset
//   pass      - 1 when done and no mismatches were seen
//   err_count - mismatching vectors, saturates at 16
//   fail_vec  - first mismatching vector, 0 if none
// Optional feature:
//   GATE_EXERCISER_STOP_ON_FAIL_EN - end the run at the first mismatch
module gate_exerciser #(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_f,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC);
    localparam logic [4:0] ERR_MAX     = 5'd16;
    localparam logic [3:0] VEC_LAST    = 4'd15;

    state_t     state;
    logic [3:0] vec;
    logic [3:0] settle_cnt;

    logic       expected;
    logic       mismatch;
    logic [4:0] err_next;

    // Expected response is derived from the registered stimulus, which
    // equals vec throughout SETTLE and SAMPLE.
    always_comb begin
        expected = ~((a & b) | (a & c) | (b & d));
        // Case inequality so that an X or Z on dut_f counts as a mismatch.
        mismatch = (dut_f !== expected);
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX)) begin
            err_next = err_count + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec        <= 4'd0;
            settle_cnt <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            c          <= 1'b0;
            d          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 5'd0;
            fail_vec   <= 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    // Stimulus outputs keep the last vector until the
                    // next DRIVE overwrites them.
                    if (start) begin
                        state     <= DRIVE;
                        vec       <= 4'd0;
                        err_count <= 5'd0;
                        fail_vec  <= 4'd0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                DRIVE: begin
                    {a, b, c, d} <= vec;
                    settle_cnt   <= SETTLE_LOAD;
                    state        <= SETTLE;
                end

                SETTLE: begin
                    // Counter is loaded with SETTLE_CYC; leaving when it
                    // reads 1 gives exactly SETTLE_CYC cycles here.
                    if (settle_cnt <= 4'd1) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && (err_count == 5'd0)) begin
                        fail_vec <= vec;
                    end
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
                    if (mismatch || (vec == VEC_LAST)) begin
`else
                    if (vec == VEC_LAST) begin
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 5'd0);
                    end else begin
                        vec   <= vec + 4'd1;
                        state <= DRIVE;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: directed and randomized runs of gate_exerciser against
// a table-driven gate model, checked with immediate assertions.
module tb_gate_exerciser;

    localparam int N = 2;
    localparam int P = N + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       dut_f;
    logic       a, b, c, d;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] fail_vec;

    // Response of the simulated gate for each input vector {a,b,c,d}.
    logic [15:0] resp;

    int n_asrt = 0;
    int n_fail = 0;

    assign dut_f = resp[{a, b, c, d}];

    gate_exerciser #(.SETTLE_CYC(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dut_f     (dut_f),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    function automatic logic gate_ref(input int v);
        int va, vb, vc, vd;
        va = (v / 8) % 2;
        vb = (v / 4) % 2;
        vc = (v / 2) % 2;
        vd = v % 2;
        return ((va * vb + va * vc + vb * vd) == 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_correct();
        for (int v = 0; v < 16; v++) resp[v] = gate_ref(v);
    endtask

    task automatic set_random();
        for (int v = 0; v < 16; v++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      resp[v] = 1'bx;
            else if (r == 1) resp[v] = 1'bz;
            else if (r < 4)  resp[v] = ~gate_ref(v);
            else             resp[v] = gate_ref(v);
        end
    endtask

    // Caller must be at a negedge; start is raised for the next edge.
    task automatic run(input string name, input int repulse_at);
        int cyc, nerr, first, exp_cyc, exp_err, exp_fail, last;
        nerr  = 0;
        first = -1;
        for (int v = 0; v < 16; v++) begin
            if (resp[v] !== gate_ref(v)) begin
                nerr++;
                if (first < 0) first = v;
            end
        end
        exp_err  = nerr;
        exp_fail = (first < 0) ? 0 : first;
        exp_cyc  = 16 * P;
        last     = 15;
`ifdef GATE_EXERCISER_STOP_ON_FAIL_EN
        if (first >= 0) begin
            exp_err = 1;
            exp_cyc = P * (first + 1);
            last    = first;
        end
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        chk({name, " busy_after_start"}, 32'(busy), 32'd1);
        chk({name, " done_low_after_start"}, 32'(done), 32'd0);
        while (done !== 1'b1 && cyc < 1000) begin
            if ((cyc % P) == 2 && (cyc / P) <= last)
                chk({name, " vec_order"}, 32'({a, b, c, d}), 32'(cyc / P));
            if (cyc == 1)
                chk({name, " pass_low_while_busy"}, 32'(pass), 32'd0);
            start = (cyc == repulse_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({name, " done_latency"}, 32'(cyc), 32'(exp_cyc));
        chk({name, " busy_low_done"}, 32'(busy), 32'd0);
        chk({name, " err_count"}, 32'(err_count), 32'(exp_err));
        chk({name, " fail_vec"}, 32'(fail_vec), 32'(exp_fail));
        chk({name, " pass"}, 32'(pass), 32'(exp_err == 0));
        chk({name, " last_vec_held"}, 32'({a, b, c, d}), 32'(last));
        repeat (2) @(negedge clk);
        chk({name, " done_held"}, 32'(done), 32'd1);
        chk({name, " err_held"}, 32'(err_count), 32'(exp_err));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_correct();
        #12;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset pass", 32'(pass), 32'd0);
        chk("reset err", 32'(err_count), 32'd0);
        chk("reset fail_vec", 32'(fail_vec), 32'd0);
        chk("reset abcd", 32'({a, b, c, d}), 32'd0);

        // Start coincides with reset release: first edge after deassertion.
        @(negedge clk);
        rst_n = 1'b1;
        run("correct", -1);

        resp = 16'h0000;
        run("stuck0", -1);

        resp = 16'hffff;
        run("stuck1", -1);

        set_correct();
        resp[9] = 1'bx;
        run("repulse", 10);

        // Mid-run reset with a faulty gate so partial errors exist.
        resp = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort pass", 32'(pass), 32'd0);
        chk("abort err", 32'(err_count), 32'd0);
        chk("abort fail_vec", 32'(fail_vec), 32'd0);
        chk("abort abcd", 32'({a, b, c, d}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_correct();
        run("after_abort", -1);

        for (int i = 0; i < 5; i++) begin
            set_random();
            run("random", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
